// File: rtl/mmu_last_stage_arb.sv
// mmu_last_stage_arb: round-robin arbiter and sequencer for the MMU single-slot last stage.
// Define MMU_LAST_ARB_TIMEOUT_EN to compile in the WAIT timeout counter and o_err[0].
module mmu_last_stage_arb #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_drive,
  input  logic             i_free,
  output logic [N_REQ-1:0] o_done,
  output logic             o_busy,
  output logic [1:0]       o_err,
  input  logic             i_err_clr
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW:0]      pick_s;
  logic             timeout_s;
  logic             spurious_s;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             drive_q, drive_d;
  logic             busy_q, busy_d;
  logic [1:0]       err_q, err_d;

`ifdef MMU_LAST_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
`else
  localparam int unused_timeout_p = TIMEOUT;
`endif

  // Rotate so that ptr sits at bit 0, take the lowest set bit, rotate the index back.
  // Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [PW-1:0]    ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [PW:0]        sum;
    logic [PW:0]        res;
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      sum = (sum >= (PW+1)'(N_REQ)) ? (sum - (PW+1)'(N_REQ)) : sum;
      res = rot[i] ? {1'b1, sum[PW-1:0]} : res;
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    logic [PW:0] s;
    s = {1'b0, idx} + (PW+1)'(1);
    return (s >= (PW+1)'(N_REQ)) ? '0 : s[PW-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_s = 1'b0;
    pick_s    = rr_pick(i_req, ptr_q);
`ifdef MMU_LAST_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_s[PW]) begin
          state_d = ST_LAUNCH;
          owner_d = pick_s[PW-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        ptr_d   = wrap_inc(owner_q);
`ifdef MMU_LAST_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (i_free) begin
          state_d = ST_IDLE;
`ifdef MMU_LAST_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d   = ST_ERR;
          timeout_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_ERR: begin
        state_d = i_err_clr ? ST_IDLE : ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered outputs and fault bits
  always_comb begin
    spurious_s = i_free && (state_q != ST_WAIT);
    busy_d     = (state_d != ST_IDLE);
    if (state_d == ST_LAUNCH) begin
      gnt_d   = onehot(owner_d);
      drive_d = 1'b1;
    end else begin
      gnt_d   = '0;
      drive_d = 1'b0;
    end
    if ((state_q == ST_WAIT) && i_free) begin
      done_d = onehot(owner_q);
    end else begin
      done_d = '0;
    end
    err_d = err_q;
    if ((state_q == ST_ERR) && i_err_clr) begin
      err_d = 2'b00;
    end else begin
      err_d[1] = err_q[1] & ~i_err_clr;
    end
    err_d[1] = err_d[1] | spurious_s;
`ifdef MMU_LAST_ARB_TIMEOUT_EN
    err_d[0] = err_d[0] | timeout_s;
`else
    err_d[0] = 1'b0;
`endif
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      drive_q <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MMU_LAST_ARB_TIMEOUT_EN
  // WAIT-cycle counter; only ever counts up to TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign o_gnt   = gnt_q;
  assign o_drive = drive_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_mmu_last_stage_arb.sv
// Self-checking bench for mmu_last_stage_arb: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_mmu_last_stage_arb;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef MMU_LAST_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE   = 0;
  localparam int P_LAUNCH = 1;
  localparam int P_WAIT   = 2;
  localparam int P_ERR    = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         free;
  logic         clr;
  logic [N-1:0] o_gnt;
  logic         o_drive;
  logic [N-1:0] o_done;
  logic         o_busy;
  logic [1:0]   o_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  int           m_phase;
  int           m_owner;
  int           m_ptr;
  int           m_waited;
  logic [1:0]   m_err;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_done;
  logic         e_drive;
  logic         e_busy;

  mmu_last_stage_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .o_gnt     (o_gnt),
    .o_drive   (o_drive),
    .i_free    (free),
    .o_done    (o_done),
    .o_busy    (o_busy),
    .o_err     (o_err),
    .i_err_clr (clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_owner  = 0;
    m_ptr    = 0;
    m_waited = 0;
    m_err    = 2'b00;
    e_gnt    = '0;
    e_done   = '0;
    e_drive  = 1'b0;
    e_busy   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int old_phase;
    int w;
    logic spur;
    old_phase = m_phase;
    spur      = free && (m_phase != P_WAIT);
    e_done    = '0;
    case (m_phase)
      P_IDLE: begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          m_owner = w;
          m_phase = P_LAUNCH;
        end
      end
      P_LAUNCH: begin
        m_ptr    = (m_owner + 1) % N;
        m_waited = 0;
        m_phase  = P_WAIT;
      end
      P_WAIT: begin
        if (free) begin
          e_done  = bit_of(m_owner);
          m_phase = P_IDLE;
        end else if (TO_EN && m_waited == TO) begin
          m_err[0] = 1'b1;
          m_phase  = P_ERR;
        end else begin
          m_waited++;
        end
      end
      default: begin
        if (clr) begin
          m_err   = 2'b00;
          m_phase = P_IDLE;
        end
      end
    endcase
    if (clr && old_phase != P_ERR) m_err[1] = 1'b0;
    if (spur) m_err[1] = 1'b1;
    e_gnt   = (m_phase == P_LAUNCH) ? bit_of(m_owner) : '0;
    e_drive = (m_phase == P_LAUNCH);
    e_busy  = (m_phase != P_IDLE);
  endtask

  task automatic compare_all();
    check_eq("gnt",   o_gnt,   e_gnt);
    check_eq("drive", o_drive, e_drive);
    check_eq("done",  o_done,  e_done);
    check_eq("busy",  o_busy,  e_busy);
    check_eq("err",   o_err,   m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // From the drive cycle, answer with i_free d cycles later (d >= 1).
  task automatic serve(input int d);
    repeat (d) tick();
    free = 1'b1;
    tick();
    free = 1'b0;
  endtask

  logic [N-1:0] held;
  logic         pend;
  int           lat;

  initial begin
    rst  = 1'b1;
    req  = '0;
    free = 1'b0;
    clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // single request, stage answers 3 cycles after drive
    req = 4'b0100;
    tick();
    check_eq("t1_gnt", o_gnt, 4'b0100);
    check_eq("t1_drive", o_drive, 1'b1);
    serve(3);
    check_eq("t1_done", o_done, 4'b0100);
    check_eq("t1_err", o_err, 2'b00);
    req = '0;

    // ptr is 3 now: 1001 must grant 3 then wrap to 0
    req = 4'b1001;
    tick();
    check_eq("wrap_gnt3", o_gnt, 4'b1000);
    serve(1);
    req = 4'b0001;
    tick();
    check_eq("wrap_gnt0", o_gnt, 4'b0001);
    serve(2);
    req = '0;

    // all requesting, immediate replies: rotation starting at ptr=1
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("rr_gnt", o_gnt, bit_of((1 + k) % N));
      tick();
      check_eq("rr_one_drive", o_drive, 1'b0);
      free = 1'b1;
      tick();
      free = 1'b0;
      check_eq("rr_done", o_done, bit_of((1 + k) % N));
    end
    req = '0;
    tick();

    // spurious free in IDLE
    free = 1'b1;
    tick();
    free = 1'b0;
    check_eq("spur_err", o_err, 2'b10);
    check_eq("spur_done", o_done, 4'b0000);
    check_eq("spur_busy", o_busy, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("spur_clr", o_err, 2'b00);

    // asynchronous reset in WAIT, then a stray free
    req = 4'b0010;
    tick();
    tick();
    check_eq("prerst_busy", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2;
    rst = 1'b0;
    req = '0;
    free = 1'b1;
    tick();
    free = 1'b0;
    check_eq("stray_err", o_err, 2'b10);
    check_eq("stray_done", o_done, 4'b0000);
    clr = 1'b1;
    tick();
    clr = 1'b0;

`ifdef MMU_LAST_ARB_TIMEOUT_EN
    // timeout: ptr=0, 1100 grants 2, no free
    req = 4'b1100;
    tick();
    check_eq("to_gnt", o_gnt, 4'b0100);
    repeat (TO + 1) tick();
    check_eq("to_not_yet", o_err, 2'b00);
    tick();
    check_eq("to_err", o_err, 2'b01);
    check_eq("to_busy", o_busy, 1'b1);
    repeat (3) tick();
    check_eq("to_no_gnt", o_gnt, 4'b0000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("to_clr", o_err, 2'b00);
    check_eq("to_idle", o_busy, 1'b0);
    tick();
    check_eq("to_next_gnt", o_gnt, 4'b1000);
    // free on the same cycle the timeout would fire
    serve(TO + 1);
    check_eq("race_done", o_done, 4'b1000);
    check_eq("race_err", o_err, 2'b00);
    req = '0;
    tick();
`else
    // without the timeout, a long wait raises nothing
    req = 4'b0001;
    tick();
    serve(20);
    check_eq("long_done", o_done, 4'b0001);
    check_eq("long_err", o_err, 2'b00);
    req = '0;
    tick();
`endif

    // random traffic
    held = '0;
    pend = 1'b0;
    lat  = 0;
    for (int c = 0; c < 3012; c++) begin
      free = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          free = 1'b1;
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
      if (o_drive) begin
        pend = 1'b1;
        lat  = $urandom_range(4, 0);
      end
      for (int i = 0; i < N; i++) begin
        if (o_gnt[i]) held[i] = 1'b1;
        if (o_done[i]) begin
          held[i] = 1'b0;
          req[i]  = 1'b0;
        end else if (c >= 3000) begin
          req[i] = held[i];
        end else if (!req[i]) begin
          req[i] = ($urandom_range(3, 0) == 0);
        end else if (!held[i] && $urandom_range(15, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    free = 1'b0;
    req  = '0;
    tick();
    check_eq("end_idle", o_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
